uart_deframe_fifo: RTL
======================

# uart_deframe_fifo

Parametrised, clocked UART receive deframer. It splits each complete parallel frame from the receive shift register into start, data, parity and stop fields. It checks parity (even/odd/none), stop bits and break, and queues data plus error flags in a small first-word-fall-through FIFO with a valid/ready handshake. It sits between the bit-level receiver and the host/bus interface, replacing the purely combinational field splitter.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal 5–9.
- `PARITY_EN`, 1: 1 means a parity bit is present after the data; 0 means none.
- `STOP_BITS`, 1: stop bits per frame; legal 1–2.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, at least 2.
- `FRAME_W` (local): 1 + DATA_BITS + PARITY_EN + STOP_BITS.
- `CNT_W` (local): $clog2(FIFO_DEPTH+1).

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_parll`  in  FRAME_W  complete frame; bit 0 is the start bit, LSB-first data follows.
- `recieved_flag`  in  1  one-cycle strobe: `data_parll` is valid this cycle.
- `parity_odd`  in  1  0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- `clr_overrun`  in  1  clears the sticky `overrun`.
- `rx_data`  out  DATA_BITS  head-entry data.
- `rx_perr`  out  1  head-entry parity error.
- `rx_ferr`  out  1  head-entry framing error.
- `rx_break`  out  1  head-entry break detected.
- `rx_valid`  out  1  FIFO non-empty; head entry is presented on the outputs.
- `rx_ready`  in  1  consumer pops the head when `rx_valid && rx_ready`.
- `overrun`  out  1  sticky: a frame was dropped because the FIFO was full.
- `fifo_count`  out  CNT_W  number of occupied entries.

## Operation
- Field extraction on `recieved_flag`:
  - start = `data_parll[0]`
  - data = `data_parll[DATA_BITS:1]`
  - parity = `data_parll[DATA_BITS+1]` when PARITY_EN=1
  - stop field = top STOP_BITS bits
- perr = PARITY_EN && (^data ^ parity ^ parity_odd); this is forced to 0 when PARITY_EN=0.
- ferr = start==1, or any stop bit ==0.
- break = the entire frame is all zeros. In that case ferr=1, and perr is reported as computed.
- Each stored entry is {break, ferr, perr, data}, DATA_BITS+3 bits wide. Frames with errors are still queued; the consumer decides whether to discard them.
- Push happens when `recieved_flag` is high and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Full, with `recieved_flag` and no pop: the frame is dropped, `overrun` is set, and the FIFO is unchanged.
- Pop happens when `rx_valid && rx_ready`.
- Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Full means `fifo_count==FIFO_DEPTH`; empty means `fifo_count==0`.
- `overrun` stays set until `clr_overrun`. If `clr_overrun` and a new overrun occur in the same cycle, set wins.
- When empty, `rx_data` and the flags are don't-care. Verification checks them only while `rx_valid`=1.

## Timing
- Reset values (asynchronous): pointers 0, `fifo_count`=0, `rx_valid`=0, `overrun`=0, `rx_data`/flags=0. The FIFO memory is not reset.
- Latency: a strobe at edge k becomes visible with `rx_valid`=1 after edge k if the FIFO was empty. This is first-word-fall-through, with the head read combinationally from memory at the read pointer.
- Pop at edge k: the next entry, or `rx_valid`=0, is presented after edge k.
- Throughput: one frame per cycle in and one out, sustained.
- Reset asserted mid-operation empties the FIFO immediately and discards all pending entries. The first strobe after deassertion is accepted normally.
- `rx_ready` may be high while `rx_valid` is low; no pop occurs.

## Structure
- Package `uart_pkg`:
  - the FRAME_W calculation function
  - the entry-layout bit-position constants (PERR, FERR, BRK offsets)
  - the even/odd encoding constants for `parity_odd`
- Sub-module `uart_sync_fifo` is a generic width/depth FWFT FIFO providing count, full and empty. `uart_deframe_fifo` contains the check logic, the overrun register and one FIFO instance.

## Test plan
All scenarios use DATA_BITS=8, PARITY_EN=1, STOP_BITS=1, FIFO_DEPTH=4 (FRAME_W=11).
- Good frame: `data_parll`=0x54A (data 0xA5, parity 0, stop 1), `parity_odd`=0 → next cycle `rx_valid`=1, `rx_data`=0xA5, perr=ferr=break=0, `fifo_count`=1.
- Parity error: same frame 0x54A with `parity_odd`=1 → `rx_data`=0xA5, perr=1, ferr=0.
- Framing error and break:
  - 0x14A → ferr=1, break=0, data 0xA5.
  - 0x000 → break=1, ferr=1, data 0x00.
- Overrun: `rx_ready`=0, five strobes with data 0x01–0x05 → `fifo_count`=4, `overrun`=1. Popping then yields 0x01–0x04 in order; `clr_overrun` returns `overrun` to 0.
- Full with simultaneous pop: FIFO holds 4 entries, strobe with 0x06 and `rx_ready`=1 in the same cycle → `fifo_count` stays 4, `overrun` stays 0, and 0x06 is the last entry popped.
- Reset mid-stream: 3 entries queued, then `rst` pulses between clock edges → `rx_valid`=0 and `fifo_count`=0 immediately. The next frame 0x54A pops as 0xA5.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive deframer.
// Entry layout: {break, ferr, perr, data}.
package uart_pkg;

  localparam int PERR_OFS = 0;
  localparam int FERR_OFS = 1;
  localparam int BRK_OFS  = 2;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int frame_w(
    input int data_bits,
    input int parity_en,
    input int stop_bits
  );
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through FIFO.
// Head is read combinationally at the read pointer.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/uart_deframe_fifo.sv
// UART receive deframer: splits frames, checks
// parity/stop/break and queues results in a FWFT FIFO.
module uart_deframe_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int FRAME_W =
    frame_w(DATA_BITS, PARITY_EN, STOP_BITS),
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FRAME_W-1:0]   data_parll,
  input  logic                 recieved_flag,
  input  logic                 parity_odd,
  input  logic                 clr_overrun,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_break,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic [CNT_W-1:0]     fifo_count
);

  localparam int ENT_W = DATA_BITS + 3;

  logic [DATA_BITS-1:0] data;
  logic                 start;
  logic                 par;
  logic [STOP_BITS-1:0] stop;
  logic                 perr;
  logic                 ferr;
  logic                 brk;
  logic [ENT_W-1:0]     din;
  logic [ENT_W-1:0]     dout;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push;
  logic                 ovr_set;

  // Field split and error checks on the incoming frame.
  always_comb begin
    start = data_parll[0];
    data  = data_parll[DATA_BITS:1];
    par   = data_parll[DATA_BITS+1];
    stop  = data_parll[FRAME_W-1 -: STOP_BITS];
    perr  = (PARITY_EN != 0) &&
            (^data ^ par ^ (parity_odd == PAR_ODD));
    ferr  = start | ~(&stop);
    brk   = ~(|data_parll);
    din   = '0;
    din[DATA_BITS-1:0]        = data;
    din[DATA_BITS + PERR_OFS] = perr;
    din[DATA_BITS + FERR_OFS] = ferr;
    din[DATA_BITS + BRK_OFS]  = brk;
  end

  assign pop     = rx_valid && rx_ready;
  assign push    = recieved_flag && (!full || pop);
  assign ovr_set = recieved_flag && full && !pop;

  uart_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign rx_valid = !empty;
  assign rx_data  = dout[DATA_BITS-1:0];
  assign rx_perr  = dout[DATA_BITS + PERR_OFS];
  assign rx_ferr  = dout[DATA_BITS + FERR_OFS];
  assign rx_break = dout[DATA_BITS + BRK_OFS];

  // Sticky overrun; a new drop outranks a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overrun <= 1'b0;
    else if (ovr_set)
      overrun <= 1'b1;
    else if (clr_overrun)
      overrun <= 1'b0;
  end

endmodule
